mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares one single-port, synchronous-read memory between the instruction-fetch port and the data (load/store) port. It sits between the IF stage / data bus and the banked main memory. It serialises accesses, grants at most one per cycle, and returns a one-cycle ack with read data. Data accesses have priority, and a starvation counter bounds fetch latency.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, synchronous-read memory between the instruction
// fetch port (if_*) and the load/store data port (d_*). At most one access is
// granted per cycle. The grant is combinational, so the memory strobe goes out
// in the same cycle as the request. The one-cycle ack, with read data, follows
// in the next cycle.
//
// Arbitration:
//   default build          - data has priority. A 4-bit starvation counter
//                            forces fetch to win once it has lost STARVE_MAX
//                            consecutive arbitrations.
//   ARB_ROUND_ROBIN_EN     - the counter is removed. A 1-bit last_grant
//                            register favours whichever requester was not
//                            granted last. Its reset value is "fetch last",
//                            so data wins the first tie.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   if_req_i, if_addr_i                fetch request / word address
//   if_rdata_o, if_ack_o               fetch read data (0 unless acked) / ack
//   d_req_i, d_we_i, d_addr_i,         data request, store flag, word address,
//   d_wdata_i, d_sel_i                 store data, byte enables
//   d_rdata_o, d_ack_o                 load data (0 unless load ack) / ack
//   mem_en_o, mem_we_o, mem_addr_o,    memory command; all driven 0 when
//   mem_wdata_o, mem_be_o              nothing is granted
//   mem_rdata_i                        memory read data, one cycle after strobe

module mem_port_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  // RESP_x: an access for requester x was issued last cycle and is acked now.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

  state_t state, state_next;

  logic elig_if, elig_d;
  logic grant_if, grant_d;

  // Set when the data access being acked is a store, so that its ack returns
  // zero instead of whatever the memory drives on its read bus.
  logic resp_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;
  logic last_grant_d_next;
`else
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;
`endif

  // State register together with the small amount of arbitration history.
  // In a reset cycle any in-flight access is abandoned, because the state
  // returns to IDLE and its ack is never raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_we      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d <= 1'b0;
`else
      starve_cnt   <= 4'd0;
`endif
    end else begin
      state        <= state_next;
      resp_we      <= grant_d & d_we_i;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d <= last_grant_d_next;
`else
      starve_cnt   <= starve_next;
`endif
    end
  end

  // Next-state and arbitration logic. The requester currently being acked
  // still holds its request line high, so it is excluded from this cycle's
  // arbitration. rst_n gates eligibility, which prevents a write from being
  // issued in a reset cycle.
  always_comb begin
    elig_if  = rst_n && if_req_i && (state != RESP_IF);
    elig_d   = rst_n && d_req_i  && (state != RESP_D);
    grant_if = 1'b0;
    grant_d  = 1'b0;

    if (elig_if && elig_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_grant_d) grant_if = 1'b1;
      else              grant_d  = 1'b1;
`else
      if (starve_cnt == 4'(STARVE_MAX)) grant_if = 1'b1;
      else                              grant_d  = 1'b1;
`endif
    end else begin
      grant_if = elig_if;
      grant_d  = elig_d;
    end

    if (grant_if)     state_next = RESP_IF;
    else if (grant_d) state_next = RESP_D;
    else              state_next = IDLE;

`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d_next = last_grant_d;
    if (grant_d)       last_grant_d_next = 1'b1;
    else if (grant_if) last_grant_d_next = 1'b0;
`else
    // Counts lost arbitrations only while fetch is actually waiting, and
    // saturates so the forced fetch win stays armed until it happens.
    starve_next = starve_cnt;
    if (!if_req_i || grant_if)
      starve_next = 4'd0;
    else if (grant_d && (starve_cnt != 4'(STARVE_MAX)))
      starve_next = starve_cnt + 4'd1;
`endif
  end

  // Output logic. The memory command mux follows the winner. Acks come from
  // the state register and are gated by rst_n, so nothing is reported during
  // reset.
  always_comb begin
    mem_en_o    = grant_if | grant_d;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (grant_d) begin
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_sel_i;
    end else if (grant_if) begin
      mem_addr_o  = if_addr_i;
    end

    if_ack_o   = rst_n && (state == RESP_IF);
    d_ack_o    = rst_n && (state == RESP_D);
    if_rdata_o = if_ack_o ? mem_rdata_i : '0;
    d_rdata_o  = (d_ack_o && !resp_we) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. A stimulus process drives both
// requesters according to the request/ack handshake. A behavioural model
// decides, from the arbitration rules, which requester gets each cycle's
// access. The model pushes the expected memory commands and acks into queues,
// and a monitor process on the falling edge pops and compares them. A small
// memory stub stands in for the banked memory. A separate model memory
// predicts the read data.

module tb_mem_port_arbiter;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [BW-1:0] d_sel_i = '0;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i = '0;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ack_o   (if_ack_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_sel_i    (d_sel_i),
    .d_rdata_o  (d_rdata_o),
    .d_ack_o    (d_ack_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o   (mem_be_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            fetch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] rdata;
  } ack_t;

  cmd_t exp_cmd[$];
  ack_t exp_if[$];
  ack_t exp_d[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [DW-1:0] stub_mem[64];
  logic [DW-1:0] ref_mem[64];

  // Reference model state: who was granted last cycle (0 none, 1 fetch,
  // 2 data), the starvation count, the last winner for round robin, and
  // whether each requester holds an outstanding request.
  int            prev_g = 0;
  int            starve = 0;
  int            last_g = 1;
  bit            if_pend = 1'b0;
  bit            d_pend = 1'b0;
  logic [DW-1:0] if_resp = '0;
  logic [DW-1:0] d_resp = '0;

  // Memory stub: synchronous read, byte-enabled write. When no read is issued
  // it drives random data, so a leak onto an ack is visible.
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) begin
      for (int b = 0; b < BW; b++)
        if (mem_be_o[b]) stub_mem[mem_addr_o[5:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    if (mem_en_o && !mem_we_o) mem_rdata_i <= stub_mem[mem_addr_o[5:0]];
    else                       mem_rdata_i <= $urandom;
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus followed by the reference model. The start
  // flags take effect only when that requester is free. A pending request is
  // held with stable fields until the cycle after its ack.
  task automatic applyStimulus(input bit rst, input bit if_start, input logic [AW-1:0] ia,
                               input bit d_start, input bit dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic [BW-1:0] ds);
    bit ack_if, ack_d, el_if, el_d;
    int g;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = !rst;
    if (!if_pend) begin
      if (if_start) begin
        if_pend   = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = ia;
      end else begin
        if_req_i  = 1'b0;
        if_addr_i = AW'($urandom);
      end
    end
    if (!d_pend) begin
      if (d_start) begin
        d_pend    = 1'b1;
        d_req_i   = 1'b1;
        d_we_i    = dwe;
        d_addr_i  = da;
        d_wdata_i = dwd;
        d_sel_i   = ds;
      end else begin
        d_req_i   = 1'b0;
        d_we_i    = 1'($urandom);
        d_addr_i  = AW'($urandom);
        d_wdata_i = $urandom;
        d_sel_i   = BW'($urandom);
      end
    end

    ack_if = !rst && (prev_g == 1);
    ack_d  = !rst && (prev_g == 2);
    if (ack_if) exp_if.push_back('{cyc: cyc, rdata: if_resp});
    if (ack_d)  exp_d.push_back('{cyc: cyc, rdata: d_resp});

    el_if = !rst && if_req_i && (prev_g != 1);
    el_d  = !rst && d_req_i  && (prev_g != 2);
    g = 0;
    if (el_if && el_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = (last_g == 2) ? 1 : 2;
`else
      g = (starve == SMAX) ? 1 : 2;
`endif
    end else if (el_if) g = 1;
    else if (el_d) g = 2;

    if (g == 1) begin
      exp_cmd.push_back('{cyc: cyc, fetch: 1'b1, we: 1'b0, addr: if_addr_i, wdata: '0, be: '0});
      if_resp = ref_mem[if_addr_i[5:0]];
    end else if (g == 2) begin
      exp_cmd.push_back('{cyc: cyc, fetch: 1'b0, we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_sel_i});
      if (d_we_i) begin
        d_resp = '0;
        for (int b = 0; b < BW; b++)
          if (d_sel_i[b]) ref_mem[d_addr_i[5:0]][8*b +: 8] = d_wdata_i[8*b +: 8];
      end else begin
        d_resp = ref_mem[d_addr_i[5:0]];
      end
    end

    if (rst) begin
      starve = 0;
      last_g = 1;
    end else begin
      if (!if_req_i || g == 1) starve = 0;
      else if (g == 2 && starve < SMAX) starve++;
      if (g != 0) last_g = g;
    end
    prev_g = g;
    if (ack_if) if_pend = 1'b0;
    if (ack_d)  d_pend  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: compares what the DUT presents this cycle with the scoreboard.
  task automatic checkOutput();
    bit   en_exp, ia_exp, da_exp;
    cmd_t c;
    ack_t a;
    en_exp = (exp_cmd.size() > 0) && (exp_cmd[0].cyc == cyc);
    checkVal("mem_en", 64'(mem_en_o), 64'(en_exp));
    if (en_exp) begin
      c = exp_cmd.pop_front();
      checkVal("mem_we",   64'(mem_we_o),   64'(c.we));
      checkVal("mem_addr", 64'(mem_addr_o), 64'(c.addr));
      checkVal("mem_be",   64'(mem_be_o),   64'(c.be));
      if (!c.fetch) checkVal("mem_wdata", 64'(mem_wdata_o), 64'(c.wdata));
    end else if (!mem_en_o) begin
      checkVal("mem_idle_addr", 64'(mem_addr_o), 64'd0);
      checkVal("mem_idle_wr", 64'({mem_we_o, mem_be_o, mem_wdata_o}), 64'd0);
    end
    while (exp_cmd.size() > 0 && exp_cmd[0].cyc < cyc) begin
      void'(exp_cmd.pop_front());
      checkVal("mem_stale", 64'd1, 64'd0);
    end

    ia_exp = (exp_if.size() > 0) && (exp_if[0].cyc == cyc);
    checkVal("if_ack", 64'(if_ack_o), 64'(ia_exp));
    if (ia_exp) begin
      a = exp_if.pop_front();
      checkVal("if_rdata", 64'(if_rdata_o), 64'(a.rdata));
    end else begin
      checkVal("if_rdata_idle", 64'(if_rdata_o), 64'd0);
    end

    da_exp = (exp_d.size() > 0) && (exp_d[0].cyc == cyc);
    checkVal("d_ack", 64'(d_ack_o), 64'(da_exp));
    if (da_exp) begin
      a = exp_d.pop_front();
      checkVal("d_rdata", 64'(d_rdata_o), 64'(a.rdata));
    end else begin
      checkVal("d_rdata_idle", 64'(d_rdata_o), 64'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      stub_mem[i] = $urandom;
      ref_mem[i]  = stub_mem[i];
    end
    stub_mem[16] = 32'h0000_0013;
    ref_mem[16]  = 32'h0000_0013;

    // Reset, then a lone fetch from 0x10 and a lone partial store to 0x20.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 30'h10, 1'b0, 1'b0, '0, '0, '0);
    idle(3);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 30'h20, 32'hAABB_CCDD, 4'b0011);
    idle(3);

    // Both requesters re-requesting as soon as they are allowed.
    for (int i = 0; i < 24; i++)
      applyStimulus(1'b0, 1'b1, AW'($urandom_range(0, 63)), 1'b1, 1'($urandom),
                    AW'($urandom_range(0, 63)), $urandom, BW'($urandom));
    idle(3);

    // Data request appearing while fetch is being acked.
    applyStimulus(1'b0, 1'b1, 30'h5, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 30'h20, '0, 4'b1111);
    idle(3);

    // Store granted, then reset in the ack cycle. The held store is re-issued.
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 30'h21, 32'h1234_5678, 4'b1111);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                    AW'($urandom_range(0, 63)), $urandom_range(0, 2) != 0, 1'($urandom),
                    AW'($urandom_range(0, 63)), $urandom, BW'($urandom));
    idle(4);

    @(negedge clk);
    #1;
    checkVal("leftover", 64'(exp_cmd.size() + exp_if.size() + exp_d.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
